// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: difference = minuend - subtrahend - borrow_in,
// computed LSB-first through one full-subtractor cell and a borrow flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             borrow_q;
    logic             a_bit, b_bit, d_bit, bout;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    always_comb begin
        a_bit = a_sr[0];
        b_bit = b_sr[0];
        d_bit = a_bit ^ b_bit ^ borrow_q;
        bout  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    end

    assign start_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            borrow_q     <= 1'b0;
            a_sr         <= '0;
            b_sr         <= '0;
            difference   <= '0;
            borrow_out   <= 1'b0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr     <= minuend;
                        b_sr     <= subtrahend;
                        borrow_q <= borrow_in;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr       <= a_sr >> 1;
                    b_sr       <= b_sr >> 1;
                    difference <= {d_bit, difference[WIDTH-1:1]};
                    borrow_q   <= bout;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Signed overflow: operand signs differ and result sign differs from minuend.
                        borrow_out   <= bout;
                        overflow     <= (a_bit != b_bit) & (d_bit != a_bit);
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on each result handshake.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] minuend = '0;
    logic [WIDTH-1:0] subtrahend = '0;
    logic             borrow_in = 1'b0;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;
    logic             overflow;
    logic             result_valid;
    logic             result_ready = 1'b1;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             b;
        logic             o;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .minuend      (minuend),
        .subtrahend   (subtrahend),
        .borrow_in    (borrow_in),
        .difference   (difference),
        .borrow_out   (borrow_out),
        .overflow     (overflow),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && result_valid && result_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got d=0x%0h, want none @%0t", difference, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("difference", 32'(difference), 32'(e.d));
                chk("borrow_out", 32'(borrow_out), 32'(e.b));
                chk("overflow", 32'(overflow), 32'(e.o));
            end
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 40 && !start_ready; k++) begin
            @(posedge clock); #1;
        end
        if (!start_ready) chk("start_ready_timeout", 32'(start_ready), 32'd1);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 60 && q.size() != 0; k++) begin
            @(posedge clock); #1;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    // Issue one operation; optionally check result_valid latency.
    task automatic do_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s, input logic bin,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic eo, input bit lat);
        exp_t e;
        wait_ready();
        minuend = m; subtrahend = s; borrow_in = bin; start_valid = 1'b1;
        e.d = ed; e.b = eb; e.o = eo;
        q.push_back(e);
        @(posedge clock); #1;
        start_valid = 1'b0;
        if (lat) begin
            for (int k = 1; k <= WIDTH; k++) begin
                @(posedge clock); #1;
                if (k == WIDTH - 1) chk("latency_low", 32'(result_valid), 32'd0);
                if (k == WIDTH)     chk("latency_high", 32'(result_valid), 32'd1);
            end
        end
        drain();
    endtask

    initial begin
        exp_t e;
        int k;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_difference", 32'(difference), 32'd0);
        chk("rst_borrow_out", 32'(borrow_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        do_op(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0, 1'b1);
        do_op(8'd5,   8'd10, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
        do_op(8'h80,  8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        do_op(8'h7F,  8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        do_op(8'h00,  8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op(8'h50,  8'h20, 1'b1, 8'h2F, 1'b0, 1'b0, 1'b0);
        do_op(8'h80,  8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);

        // Backpressure: hold DONE while new operands are offered.
        result_ready = 1'b0;
        wait_ready();
        minuend = 8'hC8; subtrahend = 8'h32; borrow_in = 1'b0; start_valid = 1'b1;
        e.d = 8'h96; e.b = 1'b0; e.o = 1'b0;
        q.push_back(e);
        @(posedge clock); #1;
        start_valid = 1'b0;
        for (k = 0; k < 40 && !result_valid; k++) begin
            @(posedge clock); #1;
        end
        chk("bp_valid", 32'(result_valid), 32'd1);
        minuend = 8'h33; subtrahend = 8'h44; borrow_in = 1'b0; start_valid = 1'b1;
        for (k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            chk("bp_hold_valid", 32'(result_valid), 32'd1);
            chk("bp_hold_ready", 32'(start_ready), 32'd0);
            chk("bp_hold_diff", 32'(difference), 32'h96);
            chk("bp_hold_borrow", 32'(borrow_out), 32'd0);
            chk("bp_hold_ovf", 32'(overflow), 32'd0);
        end
        result_ready = 1'b1;
        e.d = 8'hEF; e.b = 1'b1; e.o = 1'b0;
        q.push_back(e);
        @(posedge clock); #1;
        chk("bp_release_ready", 32'(start_ready), 32'd1);
        chk("bp_release_valid", 32'(result_valid), 32'd0);
        @(posedge clock); #1;
        start_valid = 1'b0;
        chk("bp_accept_ready", 32'(start_ready), 32'd0);
        drain();

        // Reset at the edge that would process bit 3; no result may appear.
        wait_ready();
        minuend = 8'hAA; subtrahend = 8'h55; borrow_in = 1'b0; start_valid = 1'b1;
        @(posedge clock); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        chk("abort_start_ready", 32'(start_ready), 32'd1);
        chk("abort_result_valid", 32'(result_valid), 32'd0);
        chk("abort_difference", 32'(difference), 32'd0);
        chk("abort_borrow_out", 32'(borrow_out), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        for (k = 0; k < WIDTH + 3; k++) begin
            @(posedge clock); #1;
            if (result_valid) chk("abort_no_result", 32'(result_valid), 32'd0);
        end
        do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
